// File: rtl/keyboard_matrix_pkg.sv
// ============================================================================
// Module      : keyboard_matrix_pkg
// Description : Shared sizes, types and address decode for the PET keyboard
//               matrix shadow and its Wishbone slave port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keyboard_matrix_pkg;

    localparam int KBD_COL_COUNT  = 10;
    localparam int KBD_ROW_COUNT  = 8;
    localparam int DATA_WIDTH     = 8;
    localparam int WB_ADDR_WIDTH  = 16;
    localparam int KBD_ADDR_WIDTH = 4;

    // PIA1 register selects seen by the CPU side of the io block
    localparam logic [1:0] PIA_PORTA = 2'd0;
    localparam logic [1:0] PIA_PORTB = 2'd2;

    typedef logic [KBD_ROW_COUNT-1:0] kbd_col_t;

    localparam kbd_col_t KBD_COL_IDLE = '1;

    function automatic logic [KBD_ADDR_WIDTH-1:0] wb_kbd_addr(
        input logic [WB_ADDR_WIDTH-1:0] addr
    );
        return addr[KBD_ADDR_WIDTH-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/keyboard_matrix_if.sv
// ============================================================================
// Module      : keyboard_matrix_if
// Description : Pipelined Wishbone bus bundle for the keyboard matrix slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keyboard_matrix_if;
    import keyboard_matrix_pkg::*;

    logic [KBD_ADDR_WIDTH-1:0] wb_addr_i;
    logic [DATA_WIDTH-1:0]     wb_data_i;
    logic [DATA_WIDTH-1:0]     wb_data_o;
    logic                      wb_we_i;
    logic                      wb_cycle_i;
    logic                      wb_strobe_i;
    logic                      wb_sel_i;
    logic                      wb_stall_o;
    logic                      wb_ack_o;

    modport master (
        output wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i, wb_sel_i,
        input  wb_data_o, wb_stall_o, wb_ack_o
    );

    modport slave (
        input  wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i, wb_sel_i,
        output wb_data_o, wb_stall_o, wb_ack_o
    );

endinterface

`default_nettype wire

// File: rtl/keyboard_matrix_wb_port.sv
// ============================================================================
// Module      : kbd_wb_port
// Description : Generic pipelined Wishbone accept/ack/stall handshake; one
//               ack the cycle after every accepted strobe, never stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_wb_port (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic cycle_i,
    input  wire logic strobe_i,
    output logic      accept_o,
    output logic      ack_o,
    output logic      stall_o
);

    logic ack_q;
    logic ack_d;

    assign stall_o  = 1'b0;
    assign accept_o = cycle_i & strobe_i & ~stall_o;
    assign ack_d    = accept_o;
    assign ack_o    = ack_q;

    // Ack is independent of cycle once accepted, so a dropped cycle still sees it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/keyboard_matrix.sv
// ============================================================================
// Module      : keyboard_matrix
// Description : Wishbone-writable, active-low shadow of the PET keyboard
//               matrix. Optional KBD_ANY_KEY_STATUS_EN adds a read-only
//               any-key-down status register at address KBD_COL_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keyboard_matrix
    import keyboard_matrix_pkg::*;
(
    input  wire logic                                      wb_clock_i,
    input  wire logic                                      wb_reset_ni,
    keyboard_matrix_if.slave                               wb,
    output logic [KBD_COL_COUNT-1:0][KBD_ROW_COUNT-1:0]    usb_kbd_o
);

    localparam logic [KBD_ADDR_WIDTH-1:0] COL_LIMIT = KBD_ADDR_WIDTH'(KBD_COL_COUNT);

    logic                                     accept;
    logic                                     wr_en;
    logic                                     rd_en;
    logic [KBD_COL_COUNT-1:0][KBD_ROW_COUNT-1:0] cols_q;
    logic [DATA_WIDTH-1:0]                    rdata_q;
    logic [DATA_WIDTH-1:0]                    rdata_d;

    kbd_wb_port u_wb_port (
        .clk_i    (wb_clock_i),
        .rst_ni   (wb_reset_ni),
        .cycle_i  (wb.wb_cycle_i),
        .strobe_i (wb.wb_strobe_i),
        .accept_o (accept),
        .ack_o    (wb.wb_ack_o),
        .stall_o  (wb.wb_stall_o)
    );

    // A deselected transfer is acked but touches neither the matrix nor read data
    assign wr_en = accept & wb.wb_sel_i &  wb.wb_we_i;
    assign rd_en = accept & wb.wb_sel_i & ~wb.wb_we_i;

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            cols_q <= {KBD_COL_COUNT{KBD_COL_IDLE}};
        end else begin
            for (int c = 0; c < KBD_COL_COUNT; c++) begin
                if (wr_en && (wb.wb_addr_i == KBD_ADDR_WIDTH'(c))) begin
                    cols_q[c] <= wb.wb_data_i;
                end
            end
        end
    end

    always_comb begin
        rdata_d = '1;
        for (int c = 0; c < KBD_COL_COUNT; c++) begin
            if (wb.wb_addr_i == KBD_ADDR_WIDTH'(c)) begin
                rdata_d = cols_q[c];
            end
        end
`ifdef KBD_ANY_KEY_STATUS_EN
        if (wb.wb_addr_i == COL_LIMIT) begin
            rdata_d = {{(DATA_WIDTH-1){1'b0}}, ~(&cols_q)};
        end
`else
        if (wb.wb_addr_i == COL_LIMIT) begin
            rdata_d = '1;
        end
`endif
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= rdata_d;
        end
    end

    assign wb.wb_data_o = rdata_q;
    assign usb_kbd_o    = cols_q;

endmodule

`default_nettype wire

// File: tb/tb_keyboard_matrix.sv
// ============================================================================
// Module      : tb_keyboard_matrix
// Description : Directed plus randomized Wishbone traffic against a
//               column-array model of the keyboard matrix shadow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keyboard_matrix;
    import keyboard_matrix_pkg::*;

    logic clk;
    logic rst_n;
    logic [KBD_COL_COUNT-1:0][KBD_ROW_COUNT-1:0] usb_kbd;

    keyboard_matrix_if bus ();

    keyboard_matrix dut (
        .wb_clock_i  (clk),
        .wb_reset_ni (rst_n),
        .wb          (bus),
        .usb_kbd_o   (usb_kbd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] kbd [KBD_COL_COUNT];
    logic       exp_ack;
    logic [7:0] exp_data;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [79:0] model_matrix();
        logic [79:0] m;
        for (int c = 0; c < KBD_COL_COUNT; c++) m[c*8 +: 8] = kbd[c];
        return m;
    endfunction

    function automatic logic [7:0] model_read(input int addr);
        bit any_down;
        any_down = 1'b0;
        if (addr < KBD_COL_COUNT) return kbd[addr];
`ifdef KBD_ANY_KEY_STATUS_EN
        if (addr == KBD_COL_COUNT) begin
            for (int c = 0; c < KBD_COL_COUNT; c++) if (kbd[c] != 8'hFF) any_down = 1'b1;
            return {7'b0, any_down};
        end
`endif
        return 8'hFF;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < KBD_COL_COUNT; c++) kbd[c] = 8'hFF;
        exp_ack  = 1'b0;
        exp_data = 8'h00;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ack"},   80'(bus.wb_ack_o),   80'(exp_ack));
        check({tag, ".data"},  80'(bus.wb_data_o),  80'(exp_data));
        check({tag, ".stall"}, 80'(bus.wb_stall_o), 80'(1'b0));
        check({tag, ".usb"},   80'(usb_kbd),        model_matrix());
    endtask

    // Called at a negedge: check the previous cycle's effects, drive a new request
    task automatic step(input string tag, input bit v, input bit we, input bit sel,
                        input int addr, input logic [7:0] data);
        check_outputs(tag);
        bus.wb_cycle_i  = v;
        bus.wb_strobe_i = v;
        bus.wb_we_i     = we;
        bus.wb_sel_i    = sel;
        bus.wb_addr_i   = 4'(addr);
        bus.wb_data_i   = data;
        if (v && sel) begin
            if (we) begin
                if (addr < KBD_COL_COUNT) kbd[addr] = data;
            end else begin
                exp_data = model_read(addr);
            end
        end
        exp_ack = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit         v, we, sel;
        int         addr;
        logic [7:0] data;

        rst_n           = 1'b0;
        bus.wb_cycle_i  = 1'b0;
        bus.wb_strobe_i = 1'b0;
        bus.wb_we_i     = 1'b0;
        bus.wb_sel_i    = 1'b0;
        bus.wb_addr_i   = '0;
        bus.wb_data_i   = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < KBD_COL_COUNT; c++) step("rd_reset", 1, 0, 1, c, 8'h00);
        for (int c = 0; c < KBD_COL_COUNT; c++) begin
            step("wr_50", 1, 1, 1, c, 8'h50 | 8'(c));
            step("rd_50", 1, 0, 1, c, 8'h00);
        end
        for (int c = 0; c < KBD_COL_COUNT; c++) step("rd_pass2", 1, 0, 1, c, 8'h00);
        for (int c = 0; c < KBD_COL_COUNT; c++) step("wr_ff", 1, 1, 1, c, 8'hFF);
        for (int c = 0; c < KBD_COL_COUNT; c++) step("rd_ff", 1, 0, 1, c, 8'h00);

        step("pipe_wr", 1, 1, 1, 3, 8'hA5);
        step("pipe_rd", 1, 0, 1, 3, 8'h00);
        step("pipe_end", 0, 0, 0, 0, 8'h00);
        step("pipe_rd_chk", 0, 0, 0, 0, 8'h00);
        check("pipe_rd_lit", 80'(exp_data), 80'(8'hA5));
        step("wr_ff3", 1, 1, 1, 3, 8'hFF);

        step("oor_wr", 1, 1, 1, 12, 8'h00);
        step("oor_rd", 1, 0, 1, 12, 8'h00);
        step("stat_rd0", 1, 0, 1, 10, 8'h00);
        step("col2_fe", 1, 1, 1, 2, 8'hFE);
        step("stat_rd1", 1, 0, 1, 10, 8'h00);
        step("stat_wr", 1, 1, 1, 10, 8'h00);
        step("nosel_wr", 1, 1, 0, 5, 8'h12);
        step("nosel_rd", 1, 0, 0, 2, 8'h00);

        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1) != 0;
            sel  = ($urandom_range(0, 7) != 0);
            addr = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 10))
                                               : int'($urandom_range(0, 15));
            data = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
            step("rand", v, we, sel, addr, data);
        end

        step("pre_rst", 1, 1, 1, 4, 8'h00);
        step("pre_rst2", 1, 1, 1, 5, 8'h00);
        @(posedge clk);
        #1;
        check("rst_mid.ack_before", 80'(bus.wb_ack_o), 80'(1'b1));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid");
        bus.wb_cycle_i  = 1'b0;
        bus.wb_strobe_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, 0, 0, 0, 8'h00);
        step("post_rst_rd", 1, 0, 1, 4, 8'h00);
        step("post_rst_end", 0, 0, 0, 0, 8'h00);
        check_outputs("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
